// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: arbiter (master) <-> SPI flash reader (slave) bundle.
// master drives addr/byte_count/start; slave returns rdy/data/data_valid.
interface flash_arbiter_if;
  logic [23:0] addr;
  logic [13:0] byte_count;
  logic        start;
  logic        rdy;
  logic [7:0]  data;
  logic        data_valid;

  modport master (
    output addr,
    output byte_count,
    output start,
    input  rdy,
    input  data,
    input  data_valid
  );

  modport slave (
    input  addr,
    input  byte_count,
    input  start,
    output rdy,
    output data,
    output data_valid
  );
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter: two-client round-robin sequencer for the SPI flash reader.
// Ports: clk, reset (async, low), client A/B req/addr/len -> ack/rd_valid/done, shared rd_data, busy, flash bundle.
module flash_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [23:0] addr_a,
  input  logic [23:0] addr_b,
  input  logic [13:0] len_a,
  input  logic [13:0] len_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [7:0]  rd_data,
  output logic        rd_valid_a,
  output logic        rd_valid_b,
  output logic        done_a,
  output logic        done_b,
  output logic        busy,
  flash_arbiter_if.master flash
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } state_t;

  typedef enum logic {
    CL_A,
    CL_B
  } client_t;

  state_t      state, state_n;
  client_t     owner, owner_n;
  client_t     last, last_n;
  logic [13:0] rem, rem_n;
  logic [23:0] addr_n;
  logic [13:0] cnt_n;
  logic [7:0]  data_n;
  logic        ack_a_n, ack_b_n;
  logic        val_a_n, val_b_n;
  logic        done_a_n, done_b_n;
  logic        start_n;
  logic        grant;
  logic        pick_b;
  logic [13:0] len_sel;

  // B wins when alone, or on a tie when A was served last.
  always_comb begin
    grant   = flash.rdy & (req_a | req_b);
    pick_b  = 1'b0;
    unique case (1'b1)
      req_a & req_b:  pick_b = (last == CL_A);
      req_b & ~req_a: pick_b = 1'b1;
      default:        pick_b = 1'b0;
    endcase
    len_sel = pick_b ? len_b : len_a;
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    last_n   = last;
    rem_n    = rem;
    addr_n   = flash.addr;
    cnt_n    = flash.byte_count;
    data_n   = rd_data;
    ack_a_n  = 1'b0;
    ack_b_n  = 1'b0;
    val_a_n  = 1'b0;
    val_b_n  = 1'b0;
    done_a_n = 1'b0;
    done_b_n = 1'b0;
    start_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          owner_n = pick_b ? CL_B : CL_A;
          last_n  = owner_n;
          ack_a_n = ~pick_b;
          ack_b_n = pick_b;
          addr_n  = pick_b ? addr_b : addr_a;
          cnt_n   = len_sel;
          rem_n   = len_sel;
          // Empty request completes on the spot.
          if (len_sel == '0) begin
            done_a_n = ~pick_b;
            done_b_n = pick_b;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Registered, so start lands one cycle after ack.
        start_n = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        if (flash.data_valid) begin
          data_n  = flash.data;
          val_a_n = (owner == CL_A);
          val_b_n = (owner == CL_B);
          rem_n   = rem - 14'd1;
          if (rem == 14'd1) begin
            done_a_n = (owner == CL_A);
            done_b_n = (owner == CL_B);
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      owner            <= CL_A;
      last             <= CL_B;
      rem              <= '0;
      flash.addr       <= '0;
      flash.byte_count <= '0;
      flash.start      <= 1'b0;
      rd_data          <= '0;
      ack_a            <= 1'b0;
      ack_b            <= 1'b0;
      rd_valid_a       <= 1'b0;
      rd_valid_b       <= 1'b0;
      done_a           <= 1'b0;
      done_b           <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      owner            <= owner_n;
      last             <= last_n;
      rem              <= rem_n;
      flash.addr       <= addr_n;
      flash.byte_count <= cnt_n;
      flash.start      <= start_n;
      rd_data          <= data_n;
      ack_a            <= ack_a_n;
      ack_b            <= ack_b_n;
      rd_valid_a       <= val_a_n;
      rd_valid_b       <= val_b_n;
      done_a           <= done_a_n;
      done_b           <= done_b_n;
      busy             <= (state_n != IDLE);
    end
  end

endmodule
